// File: rtl/pkt_buffer_reader_if.sv
// Bundle of descriptor, buffer-port and output-stream signals for pkt_buffer_reader.
// The master modport is the reader side; slave is the scheduler/buffer/sink side.
interface pkt_buffer_reader_if #(
    parameter int unsigned MEM_SIZE   = 1024,
    parameter int unsigned DATA_WIDTH = 16,
    parameter int unsigned LEN_WIDTH  = 8
);
    localparam int unsigned AW = $clog2(MEM_SIZE);

    logic                  req_valid;
    logic                  req_ready;
    logic [AW-1:0]         req_addr;
    logic [LEN_WIDTH-1:0]  req_len;

    logic [AW-1:0]         mem_addr;
    logic                  mem_we;
    logic [DATA_WIDTH-1:0] mem_d;
    logic [DATA_WIDTH-1:0] mem_q;

    logic                  out_valid;
    logic                  out_ready;
    logic [DATA_WIDTH-1:0] out_data;
    logic                  out_last;
    logic                  done;

    modport master (
        input  req_valid, req_addr, req_len, mem_q, out_ready,
        output req_ready, mem_addr, mem_we, mem_d, out_valid, out_data, out_last, done
    );

    modport slave (
        output req_valid, req_addr, req_len, mem_q, out_ready,
        input  req_ready, mem_addr, mem_we, mem_d, out_valid, out_data, out_last, done
    );
endinterface

// File: rtl/pkt_buffer_reader.sv
// Read-side client of the shared packet buffer: turns a (addr, len) descriptor into a
// valid/ready word stream, hiding the buffer's 1-cycle read latency behind a 2-entry FIFO.
module pkt_buffer_reader #(
    parameter int unsigned MEM_SIZE   = 1024,
    parameter int unsigned DATA_WIDTH = 16,
    parameter int unsigned LEN_WIDTH  = 8
) (
    input  logic                clk,
    input  logic                reset,
    pkt_buffer_reader_if.master bus
);
    localparam int unsigned AW = $clog2(MEM_SIZE);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        DRAIN = 2'd2
    } state_e;

    state_e                state_q, state_d;
    logic [AW-1:0]         mem_addr_q, mem_addr_d;
    logic [LEN_WIDTH-1:0]  remaining_q, remaining_d;
    logic                  inflight_q, inflight_d;
    logic                  inflight_last_q, inflight_last_d;
    logic [1:0]            count_q, count_d;
    logic [DATA_WIDTH-1:0] head_data_q, head_data_d;
    logic [DATA_WIDTH-1:0] tail_data_q, tail_data_d;
    logic                  head_last_q, head_last_d;
    logic                  tail_last_q, tail_last_d;
    logic                  out_valid_q, out_valid_d;
    logic                  out_last_q, out_last_d;
    logic                  req_ready_q, req_ready_d;
    logic                  done_q, done_d;

    logic                  pop;
    logic                  push;
    logic                  accept;
    logic                  issue;
    logic [2:0]            occupancy;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q         <= IDLE;
            mem_addr_q      <= '0;
            remaining_q     <= '0;
            inflight_q      <= 1'b0;
            inflight_last_q <= 1'b0;
            count_q         <= '0;
            head_data_q     <= '0;
            tail_data_q     <= '0;
            head_last_q     <= 1'b0;
            tail_last_q     <= 1'b0;
            out_valid_q     <= 1'b0;
            out_last_q      <= 1'b0;
            req_ready_q     <= 1'b1;
            done_q          <= 1'b0;
        end else begin
            state_q         <= state_d;
            mem_addr_q      <= mem_addr_d;
            remaining_q     <= remaining_d;
            inflight_q      <= inflight_d;
            inflight_last_q <= inflight_last_d;
            count_q         <= count_d;
            head_data_q     <= head_data_d;
            tail_data_q     <= tail_data_d;
            head_last_q     <= head_last_d;
            tail_last_q     <= tail_last_d;
            out_valid_q     <= out_valid_d;
            out_last_q      <= out_last_d;
            req_ready_q     <= req_ready_d;
            done_q          <= done_d;
        end
    end

    always_comb begin
        state_d         = state_q;
        mem_addr_d      = mem_addr_q;
        remaining_d     = remaining_q;
        count_d         = count_q;
        head_data_d     = head_data_q;
        tail_data_d     = tail_data_q;
        head_last_d     = head_last_q;
        tail_last_d     = tail_last_q;
        done_d          = 1'b0;

        pop    = out_valid_q && bus.out_ready;
        push   = inflight_q;
        accept = (state_q == IDLE) && bus.req_valid && req_ready_q;

        // Credit check: words held plus word in flight, less the one leaving, must fit.
        occupancy = 3'(count_q) + 3'(inflight_q);
        issue     = (state_q == READ) && (occupancy < (3'd2 + 3'(pop)));

        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    if (bus.req_len != '0) begin
                        mem_addr_d  = bus.req_addr;
                        remaining_d = bus.req_len;
                        state_d     = READ;
                    end else begin
                        done_d = 1'b1;
                    end
                end
            end
            READ: begin
                if (issue) begin
                    remaining_d = remaining_q - LEN_WIDTH'(1);
                    // Address stays on the final word once the last read has issued.
                    if (remaining_q == LEN_WIDTH'(1)) begin
                        state_d = DRAIN;
                    end else if (mem_addr_q == AW'(MEM_SIZE - 1)) begin
                        mem_addr_d = '0;
                    end else begin
                        mem_addr_d = mem_addr_q + AW'(1);
                    end
                end
            end
            DRAIN: begin
                if (pop && head_last_q) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase

        inflight_d      = issue;
        inflight_last_d = issue && (remaining_q == LEN_WIDTH'(1));

        // Two-entry shift FIFO: head feeds the output directly, tail only fills when head is held.
        count_d = count_q + 2'(push) - 2'(pop);
        if (pop) begin
            if (count_q == 2'd2) begin
                head_data_d = tail_data_q;
                head_last_d = tail_last_q;
                if (push) begin
                    tail_data_d = bus.mem_q;
                    tail_last_d = inflight_last_q;
                end
            end else if (push) begin
                head_data_d = bus.mem_q;
                head_last_d = inflight_last_q;
            end
        end else if (push) begin
            if (count_q == 2'd0) begin
                head_data_d = bus.mem_q;
                head_last_d = inflight_last_q;
            end else begin
                tail_data_d = bus.mem_q;
                tail_last_d = inflight_last_q;
            end
        end

        out_valid_d = (count_d != 2'd0);
        out_last_d  = (count_d != 2'd0) && head_last_d;
        req_ready_d = (state_d == IDLE);
    end

    assign bus.req_ready = req_ready_q;
    assign bus.mem_addr  = mem_addr_q;
    assign bus.mem_we    = 1'b0;
    assign bus.mem_d     = '0;
    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = head_data_q;
    assign bus.out_last  = out_last_q;
    assign bus.done      = done_q;

endmodule

// File: tb/tb_pkt_buffer_reader.sv
// Bench for pkt_buffer_reader: a word-queue model of each descriptor checked every cycle,
// plus directed scenarios with literal expectations.
module tb_pkt_buffer_reader;
    localparam int unsigned MEM_SIZE = 1024;
    localparam int unsigned DW       = 16;
    localparam int unsigned LW       = 8;
    localparam int unsigned AW       = 10;

    typedef struct {
        logic [DW-1:0] data;
        logic          last;
        int            due;
    } exp_t;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    pkt_buffer_reader_if #(.MEM_SIZE(MEM_SIZE), .DATA_WIDTH(DW), .LEN_WIDTH(LW)) bus ();

    pkt_buffer_reader #(.MEM_SIZE(MEM_SIZE), .DATA_WIDTH(DW), .LEN_WIDTH(LW)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    logic [DW-1:0] mem [MEM_SIZE];
    always @(posedge clk) bus.mem_q <= mem[bus.mem_addr];

    int            checks = 0;
    int            errors = 0;
    int            cyc    = 0;
    int            pops   = 0;
    exp_t          q[$];
    logic [DW-1:0] got_log[$];
    int            done_cycs[$];
    int            acc_cycs[$];
    bit            busy        = 1'b0;
    bit            done_exp    = 1'b0;
    bit            after_reset = 1'b0;
    bit            have_stall  = 1'b0;
    bit            bp_mode     = 1'b0;
    logic [DW-1:0] prev_data;
    logic          prev_last;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h cyc=%0d", name, got, exp, cyc);
        end
    endtask

    // Per-cycle comparison against the word-queue model.
    always @(negedge clk) begin
        if (reset) begin
            q.delete();
            busy        = 1'b0;
            done_exp    = 1'b0;
            after_reset = 1'b1;
            have_stall  = 1'b0;
        end else begin
            if (after_reset) begin
                chk("rst_out_valid", 32'(bus.out_valid), 0);
                chk("rst_out_last", 32'(bus.out_last), 0);
                chk("rst_out_data", 32'(bus.out_data), 0);
                chk("rst_mem_addr", 32'(bus.mem_addr), 0);
                after_reset = 1'b0;
            end
            chk("mem_we", 32'(bus.mem_we), 0);
            chk("mem_d", 32'(bus.mem_d), 0);
            chk("done", 32'(bus.done), 32'(done_exp));
            chk("req_ready", 32'(bus.req_ready), 32'(!busy));
            if (bus.done) done_cycs.push_back(cyc);
            if (have_stall) begin
                chk("stall_valid", 32'(bus.out_valid), 1);
                chk("stall_data", 32'(bus.out_data), 32'(prev_data));
                chk("stall_last", 32'(bus.out_last), 32'(prev_last));
            end
            done_exp = 1'b0;
            if (bus.out_valid) begin
                chk("valid_has_word", 32'(q.size() != 0), 1);
                if (bus.out_ready && q.size() != 0) begin
                    exp_t e;
                    e = q.pop_front();
                    chk("out_data", 32'(bus.out_data), 32'(e.data));
                    chk("out_last", 32'(bus.out_last), 32'(e.last));
                    if (!bp_mode) chk("word_cycle", 32'(cyc), 32'(e.due));
                    got_log.push_back(bus.out_data);
                    pops++;
                    if (e.last) begin
                        done_exp = 1'b1;
                        busy     = 1'b0;
                    end
                end
            end else begin
                chk("last_unqualified", 32'(bus.out_last), 0);
            end
            have_stall = bus.out_valid && !bus.out_ready;
            prev_data  = bus.out_data;
            prev_last  = bus.out_last;
            if (bus.req_valid && bus.req_ready) begin
                acc_cycs.push_back(cyc);
                if (bus.req_len == '0) begin
                    done_exp = 1'b1;
                end else begin
                    busy = 1'b1;
                    for (int i = 0; i < int'(bus.req_len); i++) begin
                        exp_t e;
                        e.data = mem[(int'(bus.req_addr) + i) % MEM_SIZE];
                        e.last = (i == int'(bus.req_len) - 1);
                        e.due  = cyc + 3 + i;
                        q.push_back(e);
                    end
                end
            end
        end
    end

    // Sink: always ready, or a fixed 1,0,0,1,0,1 pattern under backpressure.
    initial begin
        int pat[6] = '{1, 0, 0, 1, 0, 1};
        int idx = 0;
        bus.out_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            if (bp_mode) begin
                bus.out_ready = pat[idx % 6] != 0;
                idx++;
            end else begin
                bus.out_ready = 1'b1;
            end
        end
    end

    task automatic send(input int a, input int l);
        bus.req_addr  = AW'(a);
        bus.req_len   = LW'(l);
        bus.req_valid = 1'b1;
        for (int k = 0; k < 600; k++) begin
            @(negedge clk);
            if (bus.req_ready) begin
                @(posedge clk);
                #1;
                bus.req_valid = 1'b0;
                return;
            end
        end
        bus.req_valid = 1'b0;
        checks++;
        errors++;
        $display("FAIL send_timeout addr=%0h len=%0d", a, l);
    endtask

    task automatic wait_idle(input int budget, input string name);
        for (int k = 0; k < budget; k++) begin
            @(posedge clk);
            #1;
            if (q.size() == 0 && !busy && !done_exp) return;
        end
        checks++;
        errors++;
        $display("FAIL %s_timeout pending=%0d", name, q.size());
    endtask

    task automatic clear_logs();
        got_log.delete();
        done_cycs.delete();
        acc_cycs.delete();
        pops = 0;
    endtask

    initial begin
        reset         = 1'b1;
        bus.req_valid = 1'b0;
        bus.req_addr  = '0;
        bus.req_len   = '0;
        for (int i = 0; i < int'(MEM_SIZE); i++) mem[i] = DW'(i * 37) ^ 16'h5A5A;
        mem[16'h10] = 16'h00A0; mem[16'h11] = 16'h00A1;
        mem[16'h12] = 16'h00A2; mem[16'h13] = 16'h00A3;
        mem[1022]   = 16'hC0FE; mem[1023]   = 16'hC1FE;
        mem[0]      = 16'hC2FE; mem[1]      = 16'hC3FE;
        mem[5]      = 16'h0555;
        mem[16'h20] = 16'hD020; mem[16'h21] = 16'hD021;
        for (int i = 0; i < 6; i++) mem[16'h40 + i] = 16'h4000 + DW'(i);
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        @(posedge clk);
        #1;

        // Basic read
        clear_logs();
        send(16'h10, 4);
        wait_idle(50, "basic");
        chk("basic_count", 32'(got_log.size()), 4);
        if (got_log.size() == 4) begin
            chk("basic_w0", 32'(got_log[0]), 32'h00A0);
            chk("basic_w3", 32'(got_log[3]), 32'h00A3);
        end
        chk("basic_end_addr", 32'(bus.mem_addr), 32'h13);
        chk("basic_done_count", 32'(done_cycs.size()), 1);
        if (done_cycs.size() == 1 && acc_cycs.size() == 1)
            chk("basic_done_latency", 32'(done_cycs[0] - acc_cycs[0]), 7);

        // Wrap-around at the top of the buffer
        clear_logs();
        send(1022, 4);
        wait_idle(50, "wrap");
        chk("wrap_count", 32'(got_log.size()), 4);
        if (got_log.size() == 4) begin
            chk("wrap_w0", 32'(got_log[0]), 32'hC0FE);
            chk("wrap_w1", 32'(got_log[1]), 32'hC1FE);
            chk("wrap_w2", 32'(got_log[2]), 32'hC2FE);
            chk("wrap_w3", 32'(got_log[3]), 32'hC3FE);
        end
        chk("wrap_end_addr", 32'(bus.mem_addr), 1);

        // Backpressure
        clear_logs();
        bp_mode = 1'b1;
        @(posedge clk);
        #1;
        send(16'h40, 6);
        wait_idle(100, "bp");
        bp_mode = 1'b0;
        chk("bp_count", 32'(got_log.size()), 6);
        if (got_log.size() == 6) begin
            for (int i = 0; i < 6; i++) chk("bp_word", 32'(got_log[i]), 32'h4000 + 32'(i));
        end
        @(posedge clk);
        #1;

        // Zero length, then back-to-back single-word and two-word descriptors
        clear_logs();
        send(16'h50, 0);
        send(5, 1);
        send(16'h60, 2);
        wait_idle(50, "b2b");
        chk("b2b_count", 32'(got_log.size()), 3);
        if (got_log.size() == 3) chk("b2b_single", 32'(got_log[0]), 32'h0555);
        chk("b2b_done_count", 32'(done_cycs.size()), 3);
        chk("b2b_acc_count", 32'(acc_cycs.size()), 3);
        if (done_cycs.size() == 3 && acc_cycs.size() == 3) begin
            chk("zero_done_next", 32'(done_cycs[0] - acc_cycs[0]), 1);
            chk("zero_then_accept", 32'(acc_cycs[1]), 32'(done_cycs[0]));
            chk("accept_on_done", 32'(acc_cycs[2]), 32'(done_cycs[1]));
        end

        // Reset after the third word of an 8-word packet
        clear_logs();
        send(0, 8);
        for (int k = 0; k < 50 && pops < 3; k++) begin
            @(posedge clk);
            #1;
        end
        chk("mid_pops_before_reset", 32'(pops), 3);
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        send(16'h20, 2);
        wait_idle(50, "after_reset");
        chk("mid_count", 32'(got_log.size()), 5);
        if (got_log.size() == 5) begin
            chk("mid_w0", 32'(got_log[0]), 32'hC2FE);
            chk("mid_new0", 32'(got_log[3]), 32'hD020);
            chk("mid_new1", 32'(got_log[4]), 32'hD021);
        end
        chk("mid_done_count", 32'(done_cycs.size()), 1);

        // Maximum length, wrapping through the top of the buffer
        clear_logs();
        send(16'h380, 255);
        wait_idle(400, "max");
        chk("max_count", 32'(got_log.size()), 255);
        chk("max_done_count", 32'(done_cycs.size()), 1);
        chk("max_end_addr", 32'(bus.mem_addr), 32'h07E);
        if (done_cycs.size() == 1 && acc_cycs.size() == 1)
            chk("max_done_latency", 32'(done_cycs[0] - acc_cycs[0]), 258);

        repeat (3) @(posedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/pkt_buffer_reader.md
Name: pkt_buffer_reader

Overview:
- Read-side client of the shared dual-port packet buffer.
- Accepts a read descriptor (start word address, length in words) from the egress scheduler.
- Drives one memory port (address, write enable, write data) and absorbs the buffer's 1-cycle registered read latency.
- Streams words out on a valid/ready interface with a last-word flag and full throughput under backpressure.

Parameters:
- MEM_SIZE, 1024, number of words in the attached buffer; address width AW = $clog2(MEM_SIZE).
- DATA_WIDTH, 16, bits per buffer word.
- LEN_WIDTH, 8, width of descriptor length field (max packet 2^LEN_WIDTH-1 words).

Ports:
- clk  in  1  single clock.
- reset  in  1  synchronous, active-high reset.
- req_valid  in  1  descriptor valid.
- req_ready  out  1  block can accept a descriptor.
- req_addr  in  AW  first word address.
- req_len  in  LEN_WIDTH  word count.
- mem_addr  out  AW  buffer port address.
- mem_we  out  1  buffer port write enable; constant 0.
- mem_d  out  DATA_WIDTH  buffer port write data; constant 0.
- mem_q  in  DATA_WIDTH  buffer port registered read data: mem[addr] of the previous cycle.
- out_valid  out  1  output word valid.
- out_ready  in  1  downstream accepts.
- out_data  out  DATA_WIDTH  output word.
- out_last  out  1  final word of packet; qualified by out_valid.
- done  out  1  one-cycle pulse when a descriptor completes.

Behaviour:
- Reset values, applied on a clk edge with reset=1:
  - State IDLE; req_ready=1; out_valid=0; out_last=0; done=0.
  - mem_addr=0; out_data=0; FIFO count=0; in-flight=0.
- mem_we and mem_d are tied 0 in all states.
- Reset while in READ or DRAIN:
  - Abandon the descriptor and flush the FIFO.
  - Discard the in-flight read.
  - No done pulse.
- States:
  - IDLE: req_ready=1. On req_valid&&req_ready:
    - If req_len!=0: rd_ptr<=req_addr, remaining<=req_len, go to READ.
    - If req_len==0: go to IDLE and pulse done next cycle. No output words.
  - READ: req_ready=0. mem_addr=rd_ptr, driven from a register.
    - Issue rule: a read issues in a cycle iff (fifo_count + inflight - pop) < 2, where pop = out_valid&&out_ready.
    - On issue: rd_ptr <= (rd_ptr+1) mod MEM_SIZE, so the address wraps from MEM_SIZE-1 to 0; remaining decrements.
    - When the last word issues, go to DRAIN.
  - DRAIN: no further issues. Once the FIFO is empty and inflight=0 after the last-word handshake, go to IDLE.
- Read pipeline:
  - A word issued in cycle N appears on mem_q in cycle N+1.
  - It is pushed into a 2-entry FIFO at the end of cycle N+1, tagged last if it was the final issue.
  - inflight is 1 bit.
- Output:
  - out_valid=(fifo_count!=0). out_data and out_last come from the FIFO head.
  - Head is stable while out_valid&&!out_ready.
  - Push and pop in the same cycle are both honoured.
- Latency and throughput:
  - With acceptance edge E0 and out_ready=1, the first word is on out_valid in the cycle after edge E2.
  - Then one word per cycle, with no bubbles for any length.
- done pulses for exactly one cycle after the edge on which the out_last word handshakes.
- req_ready rises in that same cycle, so back-to-back descriptors are allowed.
- Credit rule guarantees no FIFO overflow and no dropped mem_q data regardless of the out_ready pattern.

Test Plan:
- Basic read: preload mem[0x10..0x13]=A0,A1,A2,A3; descriptor addr=0x10, len=4; out_ready=1.
  - Expect out_valid at E0+2 with A0..A3 on consecutive cycles.
  - out_last only with A3; done one cycle after A3; mem_we never 1.
- Wrap-around: MEM_SIZE=1024, addr=1022, len=4.
  - Expect mem_addr sequence 1022,1023,0,1.
  - Output mem[1022],mem[1023],mem[0],mem[1] in order.
- Backpressure: len=6, out_ready toggling 1,0,0,1,0,1...
  - Expect all 6 words in order, none dropped or duplicated.
  - out_data stable while stalled; FIFO count never exceeds 2; out_last on word 6 only.
- Zero length and back-to-back:
  - len=0: accepted, done pulses next cycle, no out_valid.
  - Immediately follow with addr=5, len=1: single word mem[5] with out_last=1.
  - Then a second descriptor accepted in the cycle done pulses.
- Reset mid-packet: addr=0, len=8; assert reset after word 3 handshakes.
  - Expect out_valid=0, req_ready=1, done=0 the cycle after reset.
  - A new descriptor addr=0x20, len=2 then returns mem[0x20], mem[0x21] with no stale words.
- Max length: len=255 with out_ready=1.
  - Expect 255 words in 255 consecutive cycles.
  - done exactly once; mem_addr ends at start+254 mod MEM_SIZE.
